// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared FSM states, reset defaults and length-mask helper for seqdet_prog
package seqdet_pkg;
    typedef enum logic [1:0] {UNCFG, HUNT, MATCH} state_t;
    localparam logic [7:0] DEFAULT_PATTERN = 8'b0001_1101;
    localparam int DEFAULT_LEN = 5;
    localparam bit DEFAULT_OVERLAP = 1'b1;
    // low len bits set; callers truncate to their pattern width
    function automatic logic [31:0] mask(input int unsigned len);
        return (len >= 32) ? '1 : (32'd1 << len) - 32'd1;
    endfunction
endpackage

// File: rtl/seqdet_hist.sv
// seqdet_hist: serial history shift register with saturating fill counter
// Ports: clock, reset (sync, active-high); shift accepts sbit; clear_fill empties the
// fill count on the shifting edge; clear_all wipes history and fill;
// hist_n/fill_n are the combinational post-shift values used for the match compare.
module seqdet_hist #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               shift,
    input  logic               sbit,
    input  logic               clear_fill,
    input  logic               clear_all,
    output logic [MAX_LEN-1:0] hist_n,
    output logic [LEN_W-1:0]   fill_n
);
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0] fill;
    always_comb begin
        hist_n = {hist[MAX_LEN-2:0], sbit};
        fill_n = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    end
    always_ff @(posedge clock)
        if (reset || clear_all) begin
            hist <= '0;
            fill <= '0;
        end else if (shift) begin
            hist <= hist_n;
            fill <= clear_fill ? '0 : fill_n;
        end
endmodule

// File: rtl/seqdet_prog.sv
// seqdet_prog: runtime-programmable serial sequence detector with Moore match pulse
// Ports: clock, reset (sync, active-high); datain sampled when din_valid;
// cfg_load latches cfg_pattern/cfg_len/cfg_overlap; dataout is the one-cycle match
// pulse; cfg_err flags an illegal cfg_len; match_count saturates at all-ones.
// Build option: SEQDET_MATCH_COUNT_EN builds the match counter, otherwise it reads 0.
module seqdet_prog
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W = $clog2(MAX_LEN + 1),
    parameter int CNT_W = 16,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(seqdet_pkg::DEFAULT_PATTERN),
    parameter int DEFAULT_LEN = seqdet_pkg::DEFAULT_LEN,
    parameter bit DEFAULT_OVERLAP = seqdet_pkg::DEFAULT_OVERLAP
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               datain,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               dataout,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_count
);
    state_t state, state_n;
    logic [MAX_LEN-1:0] pattern, hist_n;
    logic [LEN_W-1:0] len, fill_n;
    logic overlap, legal, shift, hit;
    assign legal = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);
    // a load in the same cycle as a valid bit drops the bit
    assign shift = din_valid && !cfg_load && (state != UNCFG);
    assign hit = shift && (fill_n >= len) &&
                 (((hist_n ^ pattern) & MAX_LEN'(mask(32'(len)))) == '0);
    assign dataout = (state == MATCH);
    seqdet_hist #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_hist (
        .clock      (clock),
        .reset      (reset),
        .shift      (shift),
        .sbit       (datain),
        .clear_fill (hit && !overlap),
        .clear_all  (cfg_load),
        .hist_n     (hist_n),
        .fill_n     (fill_n)
    );
    always_ff @(posedge clock)
        state <= reset ? HUNT : state_n;
    always_comb begin
        state_n = cfg_load ? (legal ? HUNT : UNCFG) :
                  (state == UNCFG) ? UNCFG : hit ? MATCH : HUNT;
    end
    always_ff @(posedge clock)
        if (reset) begin
            pattern <= DEFAULT_PATTERN;
            len     <= LEN_W'(DEFAULT_LEN);
            overlap <= DEFAULT_OVERLAP;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !legal;
            if (cfg_load) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
            end
        end
`ifdef SEQDET_MATCH_COUNT_EN
    always_ff @(posedge clock)
        if (reset || cfg_load)
            match_count <= '0;
        else if (hit && match_count != '1)
            match_count <= match_count + CNT_W'(1);
`else
    assign match_count = '0;
`endif
endmodule

// File: tb/tb_seqdet_prog.sv
// tb_seqdet_prog: directed bench for seqdet_prog against a queue-based reference model
module tb_seqdet_prog;
    localparam int ML = 8;
`ifdef SEQDET_MATCH_COUNT_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif
    logic clock = 1'b0, reset = 1'b1, datain = 1'b0, din_valid = 1'b0;
    logic cfg_load = 1'b0, cfg_overlap = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic dataout, cfg_err, dataout2, cfg_err2;
    logic [15:0] match_count;
    logic [1:0] match_count2;
    int n_cmp = 0, n_bad = 0;
    logic [7:0] m_pat = 8'h1D;
    int m_len = 5, m_cnt = 0;
    bit m_ov = 1'b1, m_cfgd = 1'b1, e_match = 1'b0, e_err = 1'b0;
    bit q[$];

    always #5 clock = ~clock;

    seqdet_prog dut (
        .clock(clock), .reset(reset), .datain(datain), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .dataout(dataout), .cfg_err(cfg_err),
        .match_count(match_count)
    );
    seqdet_prog #(.CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .datain(datain), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .dataout(dataout2), .cfg_err(cfg_err2),
        .match_count(match_count2)
    );

    function automatic int sat(input int w);
        int mx = (1 << w) - 1;
        return CEN ? ((m_cnt > mx) ? mx : m_cnt) : 0;
    endfunction

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // reference: keeps the accepted bits since the last clear and compares the newest len of them
    task automatic model(input bit rs, input bit ld, input logic [7:0] p, input int l,
                         input bit ov, input bit v, input bit d);
        e_err = 1'b0;
        e_match = 1'b0;
        if (rs) begin
            m_pat = 8'h1D; m_len = 5; m_ov = 1'b1; m_cfgd = 1'b1; m_cnt = 0;
            q.delete();
        end else if (ld) begin
            m_pat = p; m_len = l; m_ov = ov; m_cfgd = (l >= 1 && l <= ML);
            e_err = !m_cfgd; m_cnt = 0;
            q.delete();
        end else if (v && m_cfgd) begin
            q.push_back(d);
            if (q.size() > ML) void'(q.pop_front());
            e_match = (q.size() >= m_len);
            if (e_match)
                for (int i = 0; i < m_len; i++)
                    if (q[q.size() - m_len + i] != m_pat[m_len - 1 - i]) e_match = 1'b0;
            if (e_match) begin
                m_cnt++;
                if (!m_ov) q.delete();
            end
        end
    endtask

    task automatic drive(input bit rs, input bit ld, input logic [7:0] p, input int l,
                         input bit ov, input bit v, input bit d);
        reset = rs; cfg_load = ld; cfg_pattern = p; cfg_len = 4'(l);
        cfg_overlap = ov; din_valid = v; datain = d;
        @(posedge clock);
        model(rs, ld, p, l, ov, v, d);
        @(negedge clock);
        reset = 1'b0; cfg_load = 1'b0; din_valid = 1'b0;
    endtask

    task automatic rst();
        drive(1, 0, 8'h00, 0, 0, 0, 0);
    endtask
    task automatic bitv(input bit v, input bit d);
        drive(0, 0, 8'h00, 0, 0, v, d);
    endtask
    task automatic load(input logic [7:0] p, input int l, input bit ov, input bit v, input bit d);
        drive(0, 1, p, l, ov, v, d);
    endtask
    task automatic stream(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bitv(1, v[i]);
    endtask

    always @(negedge clock) begin
        check("dataout", 32'(dataout), 32'(e_match));
        check("cfg_err", 32'(cfg_err), 32'(e_err));
        check("match_count", 32'(match_count), 32'(sat(16)));
        check("dataout_w2", 32'(dataout2), 32'(e_match));
        check("cfg_err_w2", 32'(cfg_err2), 32'(e_err));
        check("match_count_w2", 32'(match_count2), 32'(sat(2)));
    end

    initial begin
        rst(); rst();
        check("rst_dataout", 32'(dataout), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        check("rst_count", 32'(match_count), 0);
        stream(32'b011101, 6);
        check("dflt_pulse", 32'(dataout), 1);
        check("dflt_count", 32'(match_count), CEN ? 1 : 0);
        bitv(0, 0);
        check("dflt_drop", 32'(dataout), 0);
        load(8'b101, 3, 1, 0, 0);
        stream(32'b101, 3);
        check("ov_pulse1", 32'(dataout), 1);
        stream(32'b01, 2);
        check("ov_pulse2", 32'(dataout), 1);
        check("ov_count", 32'(match_count), CEN ? 2 : 0);
        load(8'b101, 3, 0, 0, 0);
        stream(32'b10101, 5);
        check("nov_nopulse", 32'(dataout), 0);
        check("nov_count", 32'(match_count), CEN ? 1 : 0);
        rst();
        stream(32'b111, 3);
        for (int i = 0; i < 3; i++) bitv(0, 1);
        stream(32'b01, 2);
        check("gap_pulse", 32'(dataout), 1);
        load(8'hFF, 0, 1, 0, 0);
        check("err_pulse", 32'(cfg_err), 1);
        bitv(1, 1);
        check("err_once", 32'(cfg_err), 0);
        stream(32'b11111101, 8);
        check("uncfg_nomatch", 32'(dataout), 0);
        load(8'hFF, 9, 1, 0, 0);
        check("err_len9", 32'(cfg_err), 1);
        load(8'h01, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            bitv(1, 1);
            check("len1_pulse", 32'(dataout), 1);
        end
        check("len1_count", 32'(match_count), CEN ? 3 : 0);
        bitv(1, 0);
        rst();
        stream(32'b1110, 4);
        load(8'h1D, 5, 1, 1, 1);
        check("collide_nopulse", 32'(dataout), 0);
        check("collide_count", 32'(match_count), 0);
        load(8'h01, 1, 1, 0, 0);
        stream(32'b11111, 5);
        check("sat_count_w2", 32'(match_count2), CEN ? 3 : 0);
        check("sat_count_w16", 32'(match_count), CEN ? 5 : 0);
        load(8'b11, 2, 1, 0, 0);
        stream(32'b11, 2);
        check("midreset_pulse", 32'(dataout), 1);
        rst();
        check("midreset_drop", 32'(dataout), 0);
        stream(32'b11101, 5);
        check("midreset_default", 32'(dataout), 1);
        load(8'b1011_0110, 8, 1, 0, 0);
        stream(32'b1011_0110_1101_1011_0110_0000, 24);
        load(8'b1011_0110, 8, 0, 0, 0);
        stream(32'b1011_0110_1101_1011_0110_0000, 24);
        bitv(0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
